// File: rtl/unary_pkg.sv
// Shared types and helpers for the unary operand serializer.
package unary_pkg;

   typedef enum logic [1:0] {IDLE, STREAM, GAP} ser_state_t;

   // Bits needed to hold 0..frame_len.
   function automatic int unsigned cnt_w(input int unsigned frame_len);
      return $clog2(frame_len + 1);
   endfunction

endpackage

// File: rtl/unary_channel_gen.sv
// One unary channel: clamps and latches an operand on load, then emits a
// thermometer bit for the shared frame counter, plus the clamp flag.
module unary_channel_gen
   import unary_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned FRAME_LEN = 8,
   parameter int unsigned CW        = cnt_w(FRAME_LEN)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             stream_en,
   input  logic [CW-1:0]    cnt_d,
   input  logic [WIDTH-1:0] val_in,
   output logic             bit_o,
   output logic             sat_o
);

   logic [CW-1:0] val_q, val_d;
   logic          bit_q, bit_d;
   logic          sat_q, sat_d;
   logic          over_c;
   logic [CW-1:0] clamp_c;

   // Operand is judged against the counter value the next cycle will show.
   always_comb begin
      over_c  = val_in > WIDTH'(FRAME_LEN);
      clamp_c = over_c ? CW'(FRAME_LEN) : CW'(val_in);
      val_d   = load ? clamp_c : val_q;
      sat_d   = load ? over_c : sat_q;
      bit_d   = stream_en & (cnt_d < val_d);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         val_q <= '0;
         bit_q <= 1'b0;
         sat_q <= 1'b0;
      end else begin
         val_q <= val_d;
         bit_q <= bit_d;
         sat_q <= sat_d;
      end
   end

   assign bit_o = bit_q;
   assign sat_o = sat_q;

endmodule

// File: rtl/unary_operand_serializer.sv
// Accepts binary operand pairs and streams them as framed thermometer codes,
// with an idle gap after each frame so the downstream adder can close its count.
module unary_operand_serializer
   import unary_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned FRAME_LEN = 8,
   parameter int unsigned GAP       = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_val,
   input  logic [WIDTH-1:0] b_val,
   output logic             a,
   output logic             b,
   output logic [1:0]       ready,
   output logic             frame_done,
   output logic [1:0]       sat
);

   localparam int unsigned CW = cnt_w(FRAME_LEN);
   localparam int unsigned GW = cnt_w(GAP);

   ser_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [GW-1:0] gap_cnt_q, gap_cnt_d;
   logic [1:0]    ready_q, ready_d;
   logic          frame_done_q, frame_done_d;
   logic          in_ready_q, in_ready_d;
   logic          accept_c;
   logic          load_c;
   logic          stream_en_c;

   // Next-state, counters and registered-output inputs.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      gap_cnt_d    = gap_cnt_q;
      frame_done_d = 1'b0;
      load_c       = 1'b0;
      accept_c     = in_valid & in_ready_q;

      case (state_q)
         unary_pkg::IDLE: begin
            if (accept_c) begin
               load_c  = 1'b1;
               cnt_d   = '0;
               state_d = unary_pkg::STREAM;
            end
         end
         unary_pkg::STREAM: begin
            if (cnt_q == CW'(FRAME_LEN - 1)) begin
               state_d      = unary_pkg::GAP;
               gap_cnt_d    = '0;
               frame_done_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         unary_pkg::GAP: begin
            if (gap_cnt_q == GW'(GAP - 1)) begin
               if (accept_c) begin
                  load_c  = 1'b1;
                  cnt_d   = '0;
                  state_d = unary_pkg::STREAM;
               end else begin
                  state_d = unary_pkg::IDLE;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + GW'(1);
            end
         end
         default: state_d = unary_pkg::IDLE;
      endcase

      stream_en_c = (state_d == unary_pkg::STREAM);
      ready_d     = stream_en_c ? 2'b11 : 2'b00;
      in_ready_d  = (state_d == unary_pkg::IDLE) |
                    ((state_d == unary_pkg::GAP) & (gap_cnt_d == GW'(GAP - 1)));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= unary_pkg::IDLE;
         cnt_q        <= '0;
         gap_cnt_q    <= '0;
         ready_q      <= 2'b00;
         frame_done_q <= 1'b0;
         in_ready_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         ready_q      <= ready_d;
         frame_done_q <= frame_done_d;
         in_ready_q   <= in_ready_d;
      end
   end

   unary_channel_gen #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN), .CW(CW)) u_chan_a (
      .clk       (clk),
      .reset     (reset),
      .load      (load_c),
      .stream_en (stream_en_c),
      .cnt_d     (cnt_d),
      .val_in    (a_val),
      .bit_o     (a),
      .sat_o     (sat[0])
   );

   unary_channel_gen #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN), .CW(CW)) u_chan_b (
      .clk       (clk),
      .reset     (reset),
      .load      (load_c),
      .stream_en (stream_en_c),
      .cnt_d     (cnt_d),
      .val_in    (b_val),
      .bit_o     (b),
      .sat_o     (sat[1])
   );

   assign in_ready   = in_ready_q;
   assign ready      = ready_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_unary_operand_serializer.sv
// Bench for unary_operand_serializer: directed and random operand pairs checked
// every cycle against a frame-timing model (cycles since the last accept).
module tb_unary_operand_serializer;

   localparam int FL = 8;
   localparam int GP = 1;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a_val;
   logic [7:0] b_val;
   logic       a;
   logic       b;
   logic [1:0] ready;
   logic       frame_done;
   logic [1:0] sat;

   int checks = 0;
   int errors = 0;

   // Model state: edge index, edge of last accept, latched clamped operands.
   int         n = 0;
   int         k = 0;
   bit         active = 1'b0;
   bit         rdy_m = 1'b0;
   int         am = 0;
   int         bm = 0;
   logic [1:0] satm = 2'b00;

   unary_operand_serializer #(.WIDTH(8), .FRAME_LEN(FL), .GAP(GP)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a_val      (a_val),
      .b_val      (b_val),
      .a          (a),
      .b          (b),
      .ready      (ready),
      .frame_done (frame_done),
      .sat        (sat)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag);
      int         d;
      bit         act;
      logic [7:0] exp_v;
      logic [7:0] obs_v;
      d     = n - k;
      act   = reset && active && (d < FL);
      exp_v = {rdy_m, (act ? 2'b11 : 2'b00), (act && (d < am)), (act && (d < bm)),
               (reset && active && (d == FL)), (reset ? satm : 2'b00)};
      obs_v = {in_ready, ready, a, b, frame_done, sat};
      checks++;
      assert (obs_v === exp_v) else begin
         errors++;
         $error("FAIL %s edge=%0d observed={in_ready,ready,a,b,frame_done,sat}=%b expected=%b",
                tag, n, obs_v, exp_v);
      end
   endtask

   task automatic model_reset();
      active = 1'b0;
      rdy_m  = 1'b0;
      satm   = 2'b00;
   endtask

   // One clock edge: update the model from the pre-edge handshake, then compare.
   task automatic step(input string tag);
      bit acc;
      @(posedge clk);
      n++;
      acc = in_valid && rdy_m && reset;
      if (!reset) begin
         model_reset();
      end else begin
         if (acc) begin
            k      = n;
            active = 1'b1;
            am     = (int'(a_val) > FL) ? FL : int'(a_val);
            bm     = (int'(b_val) > FL) ? FL : int'(b_val);
            satm   = {(int'(b_val) > FL), (int'(a_val) > FL)};
         end
         rdy_m = !active || ((n - k) >= (FL + GP - 1));
      end
      #1;
      check(tag);
   endtask

   task automatic idle(input int cycles, input string tag);
      for (int i = 0; i < cycles; i++) step(tag);
   endtask

   task automatic send(input logic [7:0] av, input logic [7:0] bv, input string tag);
      int budget;
      bit done;
      budget   = 40;
      done     = 1'b0;
      in_valid = 1'b1;
      a_val    = av;
      b_val    = bv;
      while (!done && budget > 0) begin
         done = rdy_m;
         step(tag);
         budget--;
      end
      in_valid = 1'b0;
      checks++;
      assert (done) else begin
         errors++;
         $error("FAIL %s_accept_timeout observed=%0b expected=1", tag, done);
      end
   endtask

   logic [7:0] pa [4];
   logic [7:0] pb [4];

   initial begin
      int idx;
      int budget;
      bit acc;

      reset    = 1'b0;
      in_valid = 1'b0;
      a_val    = '0;
      b_val    = '0;

      // Reset held low two cycles, then released.
      idle(2, "reset_hold");
      reset = 1'b1;
      idle(2, "reset_release");

      // Directed boundary frames.
      send(8'd8, 8'd0, "full_and_empty");
      idle(FL + GP + 1, "full_and_empty_frame");
      send(8'd3, 8'd5, "three_five");
      idle(FL + GP + 1, "three_five_frame");
      send(8'd200, 8'd9, "clamp");
      idle(FL + GP, "clamp_frame");
      send(8'd1, 8'd7, "clear_sat");
      idle(FL + GP + 2, "clear_sat_frame");

      // in_valid held high across four distinct pairs.
      pa[0] = 8'd2;  pb[0] = 8'd6;
      pa[1] = 8'd7;  pb[1] = 8'd1;
      pa[2] = 8'd0;  pb[2] = 8'd8;
      pa[3] = 8'd4;  pb[3] = 8'd4;
      idx      = 0;
      budget   = 200;
      in_valid = 1'b1;
      a_val    = pa[0];
      b_val    = pb[0];
      while (idx < 4 && budget > 0) begin
         acc = rdy_m;
         step("held_valid");
         budget--;
         if (acc) begin
            idx++;
            if (idx < 4) begin
               a_val = pa[idx];
               b_val = pb[idx];
            end
         end
      end
      in_valid = 1'b0;
      checks++;
      assert (idx == 4) else begin
         errors++;
         $error("FAIL held_valid_count observed=%0d expected=4", idx);
      end
      idle(FL + GP + 1, "held_valid_tail");

      // Reset asserted mid-frame, then a clean frame afterwards.
      send(8'd6, 8'd2, "pre_reset");
      idle(3, "pre_reset_stream");
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check("async_reset");
      idle(2, "mid_reset_hold");
      reset = 1'b1;
      idle(1, "mid_reset_release");
      send(8'd5, 8'd7, "post_reset");
      idle(FL + GP + 1, "post_reset_frame");

      // Random valid pattern and operands.
      for (int i = 0; i < 150; i++) begin
         in_valid = ($urandom_range(0, 2) != 0);
         a_val = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 10)) : 8'($urandom_range(0, 255));
         b_val = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 10)) : 8'($urandom_range(0, 255));
         step("random");
      end
      in_valid = 1'b0;
      idle(FL + GP + 1, "random_tail");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
